stream_arb: RTL and testbench
=============================

Name: stream_arb

Overview:
N:1 round-robin arbiter that merges N valid-ready request streams into one registered output stream. It sits directly upstream of the per-CXU request queue: multiple CPU/hart request sources feed the arbiter, and its output drives the queue's enqueue side (i_valid/i_ready/i). Each output beat carries the index of the source it came from, so the downstream path can route the response back.

Parameters:
W, 32, payload width in bits; must be positive.
N, 4, number of input streams; must be positive; non-power-of-2 allowed.
IW, (N>1 ? $clog2(N) : 1), source-index width; derived, not overridden.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clk_en  input  1  clock enable; no state changes when 0
i_valid  input  N  per-source valid
i_ready  output  N  per-source ready; combinational
i  input  N*W  per-source payload, packed [N-1:0][W-1:0]
o_valid  output  1  output valid; registered
o_ready  input  1  downstream ready
o  output  W  output payload; registered
o_id  output  IW  source index of the current output beat; registered

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high on rst. Reset has priority over clk_en.
- Values after reset: o_valid=0, o='0, o_id='0, round-robin pointer ptr=0.
- accept = !o_valid || o_ready. accept is combinational and forwards o_ready.
- Grant selection: grant = the first index k with i_valid[k]=1, searching cyclically ptr, ptr+1, …, N-1, 0, …, ptr-1. gvalid = OR of i_valid.
- i_ready[k] = accept && gvalid && (grant==k). At most one bit of i_ready is 1. i_ready is independent of clk_en; a transfer happens only on a cycle with clk_en=1.
- Posedge with clk_en=1 and accept && gvalid:
  - o <= i[grant]; o_id <= grant; o_valid <= 1.
  - ptr <= (grant==N-1) ? 0 : grant+1. Wrap happens at N-1, not at 2^IW-1.
- Posedge with clk_en=1, o_ready=1 and no grant: o_valid <= 0. o and o_id hold their values.
- Latency: one cycle from input handshake to o_valid. Full throughput of one beat per cycle when o_ready is held at 1.
- Simultaneous dequeue and grant: the new beat replaces the old one in the same cycle, with no bubble.
- Fairness: a source that holds i_valid=1 is granted within N grant cycles.
- ptr changes only on a grant. Idle cycles do not rotate it.
- o_valid=1 with o_ready=0: o and o_id stay stable and all i_ready=0.
- Reset mid-beat: the pending output beat is dropped. Sources must not consider a beat transferred unless i_ready was 1 on a clk_en=1 edge.
- N=1: degenerates to a single stream register; o_id is always 0.
- Upstream rule: inputs must hold i and i_valid stable until their handshake completes. The arbiter may re-grant a different source if a valid is withdrawn.

Optional Feature:
- Macro: CXU_STREAM_ARB_BURST_EN.
- When defined:
  - Adds input i_last (N bits).
  - After a grant to source k whose beat has i_last[k]=0, the arbiter locks: grant is forced to k until a beat with i_last[k]=1 transfers.
  - While locked, other sources see i_ready=0. If i_valid[k]=0, no grant is made and the arbiter does not switch.
  - ptr advances only when the last beat of the burst transfers.
  - The lock flag resets to 0.
- When not defined: the i_last port is absent and every beat is arbitrated independently.

Decomposition:
- Add to common_pkg:
  - function id_width(n), returning (n>1 ? $clog2(n) : 1).
  - A check_param for N>=1, used by the initial checks.
- Sub-module rr_pick (combinational): inputs req[N] and ptr; outputs grant and gvalid.
  - Implemented as a doubled request vector with a priority encode.
  - Reused later by the response demux and other arbiters.

Test Plan:
- Reset: assert rst for 2 cycles with all i_valid=1 -> o_valid=0, o_id=0, i_ready=0 during reset. First grant after release goes to source 0.
- Round-robin, N=4, all i_valid=1, o_ready=1, i[k]=0x100+k -> o_id sequence 0,1,2,3,0,…; o=0x100,0x101,…; one beat per cycle.
- Backpressure: o_ready=0 for 3 cycles with o_valid=1 -> o/o_id stable, i_ready=4'b0000. When o_ready rises, the next beat is granted on that same edge.
- Sparse/wrap, N=3: i_valid=3'b101 with ptr=1 -> grant 2, then ptr=0 and grant 0. Confirms wrap at N-1 and that no index 3 appears.
- clk_en=0 for 2 cycles with i_valid=4'b1111 -> no state change; ptr and o are unchanged afterward.
- Burst (CXU_STREAM_ARB_BURST_EN): source 1 sends 3 beats with i_last=0,0,1 while source 2 is valid -> o_id=1,1,1 then 2.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared helpers for the stream arbiter and the blocks that reuse its round-robin picker.
package stream_arb_pkg;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit check_param(input int n);
      return n >= 1;
   endfunction

endpackage

// File: rtl/stream_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, searched cyclically.
module rr_pick
   import stream_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = id_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          gvalid
);

   logic [2*N-1:0] dbl;

   assign dbl = {req, req};

   // Doubling the request vector turns the cyclic search into a linear one from ptr.
   always_comb begin
      int  pos;
      bit  found;
      grant  = '0;
      gvalid = |req;
      found  = 1'b0;
      for (int j = 0; j < N; j++) begin
         pos = int'(ptr) + j;
         if (!found && dbl[pos]) begin
            found = 1'b1;
            grant = (pos >= N) ? IW'(pos - N) : IW'(pos);
         end
      end
   end

endmodule

// File: rtl/stream_arb.sv
// N:1 round-robin valid-ready stream arbiter with a registered output beat and source id.
// Optional CXU_STREAM_ARB_BURST_EN adds i_last and holds the grant until a burst's last beat.
module stream_arb
   import stream_arb_pkg::*;
#(
   parameter  int W  = 32,
   parameter  int N  = 4,
   localparam int IW = id_width(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic [N-1:0]        i_valid,
   output logic [N-1:0]        i_ready,
   input  logic [N-1:0][W-1:0] i,
`ifdef CXU_STREAM_ARB_BURST_EN
   input  logic [N-1:0]        i_last,
`endif
   output logic                o_valid,
   input  logic                o_ready,
   output logic [W-1:0]        o,
   output logic [IW-1:0]       o_id
);

   localparam bit PARAM_OK = check_param(N) && (W > 0);

   if (!PARAM_OK) begin : g_bad_param
      $error("stream_arb: N and W must both be at least 1");
   end

   logic [IW-1:0] ptr;
   logic [IW-1:0] rr_grant;
   logic          rr_gvalid;
   logic [IW-1:0] grant;
   logic          gvalid;
   logic          accept;
   logic          take;
   logic [IW-1:0] next_ptr;

   rr_pick #(.N(N)) u_pick (
      .req    (i_valid),
      .ptr    (ptr),
      .grant  (rr_grant),
      .gvalid (rr_gvalid)
   );

`ifdef CXU_STREAM_ARB_BURST_EN
   logic          lock;
   logic [IW-1:0] lock_id;

   // A locked burst owns the output; a gap in its valid stalls rather than switches.
   assign grant  = lock ? lock_id : rr_grant;
   assign gvalid = lock ? i_valid[lock_id] : rr_gvalid;
`else
   assign grant  = rr_grant;
   assign gvalid = rr_gvalid;
`endif

   assign accept   = !o_valid || o_ready;
   assign take     = accept && gvalid;
   assign next_ptr = (grant == IW'(N - 1)) ? '0 : grant + 1'b1;

   // Ready is withheld during reset so no source sees a handshake that reset discards.
   always_comb begin
      i_ready = '0;
      if (!rst && take) begin
         i_ready[grant] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o       <= '0;
         o_id    <= '0;
         ptr     <= '0;
`ifdef CXU_STREAM_ARB_BURST_EN
         lock    <= 1'b0;
         lock_id <= '0;
`endif
      end else if (clk_en) begin
         if (take) begin
            o       <= i[grant];
            o_id    <= grant;
            o_valid <= 1'b1;
`ifdef CXU_STREAM_ARB_BURST_EN
            if (i_last[grant]) begin
               lock <= 1'b0;
               ptr  <= next_ptr;
            end else begin
               lock    <= 1'b1;
               lock_id <= grant;
            end
`else
            ptr     <= next_ptr;
`endif
         end else if (o_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_arb.sv
// Directed self-checking bench for stream_arb: N=4 vector table plus N=3 wrap and burst sequences.
module tb_stream_arb;

   logic                clk;
   logic                rst;
   logic                clk_en;
   logic                o_ready;

   logic [3:0]          valid4;
   logic [3:0]          ready4;
   logic [3:0][31:0]    data4;
   logic                ovalid4;
   logic [31:0]         o4;
   logic [1:0]          oid4;

   logic [2:0]          valid3;
   logic [2:0]          ready3;
   logic [2:0][31:0]    data3;
   logic                ovalid3;
   logic [31:0]         o3;
   logic [1:0]          oid3;

`ifdef CXU_STREAM_ARB_BURST_EN
   logic [3:0]          last4;
   logic [2:0]          last3;
`endif

   int checks;
   int failures;

   stream_arb #(.W(32), .N(4)) dut4 (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .i_valid (valid4),
      .i_ready (ready4),
      .i       (data4),
`ifdef CXU_STREAM_ARB_BURST_EN
      .i_last  (last4),
`endif
      .o_valid (ovalid4),
      .o_ready (o_ready),
      .o       (o4),
      .o_id    (oid4)
   );

   stream_arb #(.W(32), .N(3)) dut3 (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .i_valid (valid3),
      .i_ready (ready3),
      .i       (data3),
`ifdef CXU_STREAM_ARB_BURST_EN
      .i_last  (last3),
`endif
      .o_valid (ovalid3),
      .o_ready (o_ready),
      .o       (o3),
      .o_id    (oid3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic        ordy;
      logic        en;
      logic [3:0]  exp_ready;
      logic        exp_ovalid;
      logic [1:0]  exp_id;
      logic [31:0] exp_o;
   } vec_t;

   vec_t vecs[18];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs are driven 1ns after a posedge; ready is checked before the next edge, registers after it.
   task automatic applyStimulus(input string name, input logic [3:0] v, input logic ordy,
                                input logic en, input logic [3:0] exp_ready,
                                input logic exp_ov, input logic [1:0] exp_id,
                                input logic [31:0] exp_o);
      valid4  = v;
      o_ready = ordy;
      clk_en  = en;
      #1;
      checkOutput({name, ".i_ready"}, 32'(ready4), 32'(exp_ready));
      @(posedge clk);
      #1;
      checkOutput({name, ".o_valid"}, 32'(ovalid4), 32'(exp_ov));
      checkOutput({name, ".o_id"}, 32'(oid4), 32'(exp_id));
      checkOutput({name, ".o"}, o4, exp_o);
   endtask

   task automatic step3(input string name, input logic [2:0] v, input logic [2:0] exp_ready,
                        input logic exp_ov, input logic [1:0] exp_id, input logic [31:0] exp_o);
      valid3 = v;
      #1;
      checkOutput({name, ".i_ready"}, 32'(ready3), 32'(exp_ready));
      @(posedge clk);
      #1;
      checkOutput({name, ".o_valid"}, 32'(ovalid3), 32'(exp_ov));
      checkOutput({name, ".o_id"}, 32'(oid3), 32'(exp_id));
      checkOutput({name, ".o"}, o3, exp_o);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int k = 0; k < 4; k++) data4[k] = 32'h100 + 32'(k);
      for (int k = 0; k < 3; k++) data3[k] = 32'h200 + 32'(k);
`ifdef CXU_STREAM_ARB_BURST_EN
      last4 = '1;
      last3 = '1;
`endif
      valid3  = '0;
      valid4  = 4'b1111;
      o_ready = 1'b1;
      clk_en  = 1'b1;
      rst     = 1'b1;

      //                valid    ordy  en    ready    ov    id     o
      vecs[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};
      vecs[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101};
      vecs[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102};
      vecs[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h103};
      vecs[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};
      vecs[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h100};
      vecs[6]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h100};
      vecs[7]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h100};
      vecs[8]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101};
      vecs[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 32'h101};
      vecs[10] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 32'h101};
      vecs[11] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102};
      vecs[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h102};
      vecs[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h102};
      vecs[14] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h103};
      vecs[15] = '{4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101};
      vecs[16] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h101};
      vecs[17] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100};

      // Two reset cycles with every source valid: nothing may be readied or registered.
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checkOutput("reset.i_ready", 32'(ready4), 32'h0);
         @(posedge clk);
         #1;
         checkOutput("reset.o_valid", 32'(ovalid4), 32'h0);
         checkOutput("reset.o_id", 32'(oid4), 32'h0);
         checkOutput("reset.o", o4, 32'h0);
      end
      rst = 1'b0;

      for (int n = 0; n < 18; n++) begin
         applyStimulus($sformatf("vec%0d", n), vecs[n].valid, vecs[n].ordy, vecs[n].en,
                       vecs[n].exp_ready, vecs[n].exp_ovalid, vecs[n].exp_id, vecs[n].exp_o);
      end

      // Reset while a beat is pending and clk_en is low: reset still wins and drops the beat.
      valid4 = 4'b0000;
      clk_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset.o_valid", 32'(ovalid4), 32'h0);
      checkOutput("midreset.o_id", 32'(oid4), 32'h0);
      checkOutput("midreset.o", o4, 32'h0);
      rst = 1'b0;
      applyStimulus("postreset", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h100);
      valid4 = 4'b0000;
      @(posedge clk);
      #1;

      // N=3: move ptr to 1, then 3'b101 must pick 2, wrap ptr to 0, and pick 0.
      step3("n3.first", 3'b001, 3'b001, 1'b1, 2'd0, 32'h200);
      step3("n3.skip", 3'b101, 3'b100, 1'b1, 2'd2, 32'h202);
      step3("n3.wrap", 3'b101, 3'b001, 1'b1, 2'd0, 32'h200);
      step3("n3.next", 3'b111, 3'b010, 1'b1, 2'd1, 32'h201);
      step3("n3.idle", 3'b000, 3'b000, 1'b0, 2'd1, 32'h201);
      valid3 = '0;

`ifdef CXU_STREAM_ARB_BURST_EN
      // Source 1 holds a 3-beat burst while source 2 waits; a valid gap stalls the lock.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      last4 = 4'b0000;
      applyStimulus("burst.b0", 4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101);
      applyStimulus("burst.b1", 4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101);
      applyStimulus("burst.gap", 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h101);
      last4 = 4'b0010;
      applyStimulus("burst.b2", 4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101);
      last4 = 4'b1111;
      applyStimulus("burst.next", 4'b0110, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h102);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
